// File: rtl/sound_mailbox_if.sv
// Command/reply bus between the 68k host, the Z80 sound CPU and the sound mailbox.
// The master modport drives the strobes and data; the slave is the mailbox itself.
interface sound_mailbox_if;
    logic       M68K_WR;
    logic [7:0] M68K_DATA;
    logic       M68K_RD;
    logic       Z80_RD;
    logic       Z80_CLR;
    logic       Z80_WR;
    logic [7:0] Z80_DATA;
    logic       NMI_EN_SET;
    logic       NMI_EN_VAL;
    logic [7:0] SND_CODE;
    logic [7:0] REPLY;
    logic       nZ80NMI;
    logic       CMD_PENDING;
    logic       REPLY_VALID;
    logic       OVERRUN;

    modport master (
        output M68K_WR, M68K_DATA, M68K_RD, Z80_RD, Z80_CLR, Z80_WR, Z80_DATA,
               NMI_EN_SET, NMI_EN_VAL,
        input  SND_CODE, REPLY, nZ80NMI, CMD_PENDING, REPLY_VALID, OVERRUN
    );

    modport slave (
        input  M68K_WR, M68K_DATA, M68K_RD, Z80_RD, Z80_CLR, Z80_WR, Z80_DATA,
               NMI_EN_SET, NMI_EN_VAL,
        output SND_CODE, REPLY, nZ80NMI, CMD_PENDING, REPLY_VALID, OVERRUN
    );
endinterface

// File: rtl/sound_mailbox.sv
// 68k <-> Z80 sound mailbox: command latch with NMI sequencer, reply latch, overrun flag.
// Every output comes straight from a flop.
module sound_mailbox #(
    parameter int unsigned NMI_WIDTH = 8
) (
    input  logic          CLK_24M,
    input  logic          nRESET,
    sound_mailbox_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        WAIT_ACK
    } nmi_state_t;

    localparam logic [7:0] PULSE_LEN = 8'(NMI_WIDTH);

    nmi_state_t state;
    logic [7:0] cnt;
    logic       nmi_en;
    logic       nmi_n;
    logic [7:0] snd_code;
    logic [7:0] reply;
    logic       cmd_pending;
    logic       reply_valid;
    logic       overrun;

    logic ack;
    logic disable_req;

    assign ack         = bus.Z80_RD | bus.Z80_CLR;
    assign disable_req = bus.NMI_EN_SET & ~bus.NMI_EN_VAL;

    // NOTE: every flop, including nmi_n, is in the async reset so a reset mid-pulse
    // releases the NMI immediately; all state updates use non-blocking assignments.
    always_ff @(posedge CLK_24M or negedge nRESET) begin
        if (!nRESET) begin
            state  <= IDLE;
            cnt    <= '0;
            nmi_en <= 1'b0;
            nmi_n  <= 1'b1;
        end else begin
            if (bus.NMI_EN_SET) nmi_en <= bus.NMI_EN_VAL;

            if (bus.M68K_WR && ack) begin
                // A fresh command beats the acknowledge and re-arms the sequencer.
                state <= nmi_en ? PULSE : IDLE;
                cnt   <= nmi_en ? PULSE_LEN : 8'd0;
                nmi_n <= ~nmi_en;
            end else begin
                case (state)
                    IDLE: begin
                        // A pending command that is being read/cleared right now needs no NMI.
                        if (nmi_en && (bus.M68K_WR || (cmd_pending && !ack))) begin
                            state <= PULSE;
                            cnt   <= PULSE_LEN;
                            nmi_n <= 1'b0;
                        end
                    end
                    PULSE: begin
                        if (ack) begin
                            state <= IDLE;
                            cnt   <= '0;
                            nmi_n <= 1'b1;
                        end else if (disable_req || cnt <= 8'd1) begin
                            state <= WAIT_ACK;
                            cnt   <= '0;
                            nmi_n <= 1'b1;
                        end else begin
                            cnt <= cnt - 8'd1;
                        end
                    end
                    WAIT_ACK: begin
                        if (ack) state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                        nmi_n <= 1'b1;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge CLK_24M or negedge nRESET) begin
        if (!nRESET) begin
            snd_code    <= '0;
            reply       <= '0;
            cmd_pending <= 1'b0;
            reply_valid <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            if (bus.M68K_WR) begin
                snd_code    <= bus.M68K_DATA;
                cmd_pending <= 1'b1;
                overrun     <= ack ? 1'b0 : (overrun | cmd_pending);
            end else if (bus.Z80_CLR) begin
                snd_code    <= '0;
                cmd_pending <= 1'b0;
                overrun     <= 1'b0;
            end else if (bus.Z80_RD) begin
                cmd_pending <= 1'b0;
            end

            if (bus.Z80_WR) begin
                reply       <= bus.Z80_DATA;
                reply_valid <= 1'b1;
            end else if (bus.M68K_RD) begin
                reply_valid <= 1'b0;
            end
        end
    end

    assign bus.SND_CODE    = snd_code;
    assign bus.REPLY       = reply;
    assign bus.nZ80NMI     = nmi_n;
    assign bus.CMD_PENDING = cmd_pending;
    assign bus.REPLY_VALID = reply_valid;
    assign bus.OVERRUN     = overrun;

endmodule
